// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [7:0]  B_AL_OPCODE    = 8'hEA;
    localparam logic [31:0] PC_STEP        = 32'd4;
    localparam logic [31:0] PC_READ_OFFSET = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } fetch_entry_t;

    // ARM B target: PC-read value plus sign-extended word offset
    function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] instr);
        return pc + PC_READ_OFFSET + {{6{instr[23]}}, instr[23:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO of fetch entries with flush; read data is the head slot.
// Latency: a pushed entry is visible at rd_dat the cycle after the push.
// Backpressure: caller must not push when full without popping; flush beats push/pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wr_dat,
    output fetch_entry_t             rd_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= wr_dat;
                tail      <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    assign rd_dat = mem[head];
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC, reads ROM, queues {instr,pc,pred}; FETCH_PREDECODE_EN adds B-AL early redirect.
// Latency: word fetched in cycle N reaches out_* in N+1 when the queue was empty.
// Backpressure: out_ready low fills the queue, then the PC freezes; redirect flushes everything.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus8,
    output logic        out_pred_taken
);

    logic [31:0]            pc;
    logic [31:0]            next_pc;
    logic                   pred;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t           wr_entry;
    fetch_entry_t           head;

`ifdef FETCH_PREDECODE_EN
    assign pred    = (imem_rd[31:24] == B_AL_OPCODE);
    assign next_pc = pred ? branch_target(pc, imem_rd) : pc + PC_STEP;
`else
    assign pred    = 1'b0;
    assign next_pc = pc + PC_STEP;
`endif

    assign imem_addr = pc;
    assign pop       = out_valid && out_ready;
    // Full queue can still take a word when the head leaves in the same cycle
    assign push      = !redirect_valid && (!full || pop);

    assign wr_entry.instr = imem_rd;
    assign wr_entry.pc    = pc;
    assign wr_entry.pred  = pred;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= PC_RESET;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~32'h3;
        end else if (push) begin
            pc <= next_pc;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_valid),
        .wr_dat (wr_entry),
        .rd_dat (head),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    assign out_valid      = !empty;
    assign out_instr      = head.instr;
    assign out_pc         = head.pc;
    assign out_pc_plus8   = head.pc + PC_READ_OFFSET;
    assign out_pred_taken = head.pred;

    a_count_bound: assert property (@(posedge clk) int'(count) <= DEPTH);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed literal checks plus randomized handshake/redirect/reset traffic
// compared every cycle against a queue-level reference model.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] PC_RESET = 32'h0000_0000;
`ifdef FETCH_PREDECODE_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus8;
    logic        out_pred_taken;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [256];

    fetch_unit #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus8   (out_pc_plus8),
        .out_pred_taken (out_pred_taken)
    );

    assign imem_rd = rom[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch pointer plus a bounded queue of expected head entries
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        mq [$];
    logic [31:0] mpc = PC_RESET;

    always @(posedge clk) begin
        ent_t        e;
        logic [31:0] w;
        if (reset) begin
            mq.delete();
            mpc = PC_RESET;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (mq.size() > 0 && out_ready) begin
                void'(mq.pop_front());
            end
            if (mq.size() < DEPTH) begin
                w       = rom[mpc[9:2]];
                e.instr = w;
                e.pc    = mpc;
                e.pred  = PRED && (w[31:24] == 8'hEA);
                mq.push_back(e);
                if (e.pred) begin
                    mpc = mpc + 32'd8 + {{6{w[23]}}, w[23:0], 2'b00};
                end else begin
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m_imem_addr", imem_addr, mpc);
        check("m_out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("m_out_instr", out_instr, mq[0].instr);
            check("m_out_pc", out_pc, mq[0].pc);
            check("m_out_pc_plus8", out_pc_plus8, mq[0].pc + 32'd8);
            check("m_out_pred", {31'd0, out_pred_taken}, {31'd0, mq[0].pred});
        end
    end

    initial begin
        int bias;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'hE3, 24'($urandom)};
            if (i >= 32 && (i % 13) == 7) rom[i] = {8'hEA, 24'($urandom)};
        end
        rom[0]   = 32'hE3A0_00AA;
        rom[1]   = 32'hE3A0_1055;
        rom[2]   = 32'hE3A0_20FF;
        rom[24]  = 32'hE3A0_0000;
        rom[122] = 32'hEAFF_FFFE;

        // Reset values
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_imem_addr", imem_addr, PC_RESET);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_pred", {31'd0, out_pred_taken}, 32'd0);

        // Streaming from reset
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("seq0_valid", {31'd0, out_valid}, 32'd1);
        check("seq0_instr", out_instr, 32'hE3A0_00AA);
        check("seq0_pc", out_pc, 32'h0);
        @(negedge clk);
        check("seq1_instr", out_instr, 32'hE3A0_1055);
        check("seq1_pc", out_pc, 32'h4);
        @(negedge clk);
        check("seq2_instr", out_instr, 32'hE3A0_20FF);
        check("seq2_pc", out_pc, 32'h8);
        check("seq2_plus8", out_pc_plus8, 32'h10);

        // Backpressure until full, then full+pop, then resume
        reset = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_freeze_a", imem_addr, 32'(4 * DEPTH));
        @(negedge clk);
        check("bp_freeze_b", imem_addr, 32'(4 * DEPTH));
        check("bp_head", out_pc, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("fullpop_head", out_pc, 32'h4);
        check("fullpop_addr", imem_addr, 32'hC);
        @(negedge clk);
        check("fullpop_hold_head", out_pc, 32'h4);
        check("fullpop_hold_addr", imem_addr, 32'hC);
        out_ready = 1'b1;
        @(negedge clk);
        check("resume_pc8", out_pc, 32'h8);
        @(negedge clk);
        check("resume_pcC", out_pc, 32'hC);

        // Redirect with misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0063;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("redir_valid", {31'd0, out_valid}, 32'd0);
        check("redir_addr", imem_addr, 32'h60);
        @(negedge clk);
        check("redir_head_instr", out_instr, 32'hE3A0_0000);
        check("redir_head_pc", out_pc, 32'h60);

        // Branch-to-self predecode
        redirect_valid = 1'b1; redirect_pc = 32'h0000_01E8;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("pd_addr0", imem_addr, 32'h1E8);
        @(negedge clk);
        check("pd_head_pc", out_pc, 32'h1E8);
        check("pd_pred", {31'd0, out_pred_taken}, {31'd0, PRED});
        check("pd_addr1", imem_addr, PRED ? 32'h1E8 : 32'h1EC);

        // Reset beats a simultaneous redirect
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b0;
        check("rstredir_addr", imem_addr, PC_RESET);
        check("rstredir_valid", {31'd0, out_valid}, 32'd0);

        // Randomized traffic, model-checked every cycle
        bias = 50;
        for (int c = 0; c < 4000; c++) begin
            if ((c % 250) == 0) bias = $urandom_range(10, 100);
            out_ready      = ($urandom_range(99, 0) < bias);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = $urandom & 32'h0000_03FF;
            reset          = ($urandom_range(199, 0) == 0);
            @(negedge clk);
        end
        reset = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
